bus_xbar_rr: RTL and testbench

- Parametrised successor to the fixed two-master/two-SRAM instruction/data bus.
- Connects NUM_M bus masters (core IMEM port, core DMEM port, DMA, ...) to NUM_S single-cycle SRAM-style slaves.
- Address decode is programmable by base/mask per slave.
- Each slave has its own round-robin arbiter; a registered response path returns read data with a valid flag.

---
 rtl/bus_xbar_pkg.sv | 48 ++++
 rtl/rr_arbiter.sv | 40 ++++
 rtl/bus_xbar_rr.sv | 148 ++++++++++++++
 tb/tb_bus_xbar_rr.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_xbar_pkg.sv
// Shared definitions for the bus_xbar_rr crossbar: size codes, decode-error data,
// and the round-robin search helpers used by every per-slave arbiter.
// Helpers work on 32-bit request vectors, so NUM_M is limited to 32 masters.
package bus_xbar_pkg;

   // Byte-enable/size codes carried unchanged from master to slave.
   localparam logic [3:0] SIZE_BYTE = 4'h1;
   localparam logic [3:0] SIZE_HALF = 4'h3;
   localparam logic [3:0] SIZE_WORD = 4'hF;

   // Read data returned for an unmapped access when decode errors are enabled.
   localparam logic [31:0] DECERR_DATA = 32'hBADD_ADD0;

   typedef struct packed {
      logic       found;
      logic [4:0] idx;
   } pick_t;

   function automatic logic [4:0] onehot_to_idx(input logic [31:0] oh);
      logic [4:0] idx;
      idx = '0;
      for (int i = 0; i < 32; i++) begin
         if (oh[i]) idx = 5'(i);
      end
      return idx;
   endfunction

   // First requester at or after ptr, wrapping modulo n. The scan runs from the
   // farthest offset down so the nearest offset is the last one written.
   function automatic pick_t rr_pick(input logic [31:0] req, input logic [4:0] ptr,
                                     input int n);
      pick_t r;
      int    k;
      r = '0;
      for (int i = 31; i >= 0; i--) begin
         if (i < n) begin
            k = int'(ptr) + i;
            if (k >= n) k = k - n;
            if (req[k[4:0]]) begin
               r.found = 1'b1;
               r.idx   = k[4:0];
            end
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter for one slave port of bus_xbar_rr.
// Latency: grant is combinational from i_req; pointer updates on the clock edge.
// Backpressure: losers see no grant and must hold their request.
// Ports: i_clk/i_rst (async active-high), i_req[N] candidates, i_adv lets the
// pointer move past the winner, o_gnt[N] one-hot grant, o_idx winner index.
module rr_arbiter
   import bus_xbar_pkg::*;
#(
   parameter  int N  = 3,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic [N-1:0]  i_req,
   input  logic          i_adv,
   output logic [N-1:0]  o_gnt,
   output logic [IW-1:0] o_idx
);

   logic [IW-1:0] ptr_q;
   logic [IW-1:0] ptr_d;
   pick_t         pick;

   always_comb begin
      pick  = rr_pick(32'(i_req), 5'(ptr_q), N);
      o_gnt = pick.found ? (N'(1) << pick.idx) : '0;
      o_idx = IW'(onehot_to_idx(32'(o_gnt)));
      ptr_d = ptr_q;
      // The winner becomes lowest priority on the next cycle.
      if (i_adv && pick.found) begin
         ptr_d = (int'(pick.idx) + 1 >= N) ? '0 : IW'(int'(pick.idx) + 1);
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) ptr_q <= '0;
      else       ptr_q <= ptr_d;
   end

endmodule

// File: rtl/bus_xbar_rr.sv
// NUM_M-master to NUM_S-slave SRAM bus crossbar, base/mask decode, round-robin per slave.
// Latency: grant and slave strobes combinational; read data/rvalid one cycle after grant.
// Backpressure: an ungranted master gets o_m_gnt=0 and holds request and fields.
// Ports: i_m_* / o_m_gnt,o_m_dout,o_m_rvalid master side (packed per master);
// o_s_* / i_s_dout slave side (packed per slave); i_clk, i_rst async active-high.
// Option BUS_XBAR_DECERR_EN: unmapped requests are granted, reads return
// DECERR_DATA, and sticky o_decerr is added.
module bus_xbar_rr
   import bus_xbar_pkg::*;
#(
   parameter int                    XLEN     = 32,
   parameter int                    NUM_M    = 3,
   parameter int                    NUM_S    = 2,
   parameter logic [NUM_S*XLEN-1:0] SLV_BASE = {32'h4000_4000, 32'h4000_0000},
   parameter logic [NUM_S*XLEN-1:0] SLV_MASK = {32'hFFFF_C000, 32'hFFFF_C000}
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic [NUM_M-1:0]        i_m_req,
   output logic [NUM_M-1:0]        o_m_gnt,
   input  logic [NUM_M*XLEN-1:0]   i_m_addr,
   input  logic [NUM_M-1:0]        i_m_write,
   input  logic [NUM_M-1:0]        i_m_read,
   input  logic [NUM_M*4-1:0]      i_m_size,
   input  logic [NUM_M*XLEN-1:0]   i_m_din,
   output logic [NUM_M*XLEN-1:0]   o_m_dout,
   output logic [NUM_M-1:0]        o_m_rvalid,
`ifdef BUS_XBAR_DECERR_EN
   output logic                    o_decerr,
`endif
   output logic [NUM_S*XLEN-1:0]   o_s_addr,
   output logic [NUM_S-1:0]        o_s_write,
   output logic [NUM_S-1:0]        o_s_read,
   output logic [NUM_S*4-1:0]      o_s_size,
   output logic [NUM_S*XLEN-1:0]   o_s_din,
   input  logic [NUM_S*XLEN-1:0]   i_s_dout
);

   localparam int MW = (NUM_M > 1) ? $clog2(NUM_M) : 1;
   localparam int SW = (NUM_S > 1) ? $clog2(NUM_S) : 1;

   logic [NUM_M-1:0]           m_hit;
   logic [NUM_M-1:0][SW-1:0]   m_tgt;
   logic [NUM_S-1:0][NUM_M-1:0] cand;
   logic [NUM_S-1:0][NUM_M-1:0] s_gnt;
   logic [NUM_S-1:0][MW-1:0]   s_idx;
   logic [NUM_M-1:0]           rsp_vld_d, rsp_vld_q;
   logic [NUM_M-1:0][SW-1:0]   rsp_sel_d, rsp_sel_q;

   // Decode: scanning slaves downward lets the lowest matching slave win.
   always_comb begin
      m_hit = '0;
      m_tgt = '0;
      cand  = '0;
      for (int m = 0; m < NUM_M; m++) begin
         for (int s = NUM_S - 1; s >= 0; s--) begin
            if ((i_m_addr[m*XLEN +: XLEN] & SLV_MASK[s*XLEN +: XLEN]) ==
                SLV_BASE[s*XLEN +: XLEN]) begin
               m_hit[m] = 1'b1;
               m_tgt[m] = SW'(s);
            end
         end
         if (i_m_req[m] && m_hit[m]) cand[m_tgt[m]][m] = 1'b1;
      end
   end

   for (genvar s = 0; s < NUM_S; s++) begin : g_arb
      rr_arbiter #(.N(NUM_M)) u_arb (
         .i_clk (i_clk),
         .i_rst (i_rst),
         .i_req (cand[s]),
         .i_adv (1'b1),
         .o_gnt (s_gnt[s]),
         .o_idx (s_idx[s])
      );
   end

`ifdef BUS_XBAR_DECERR_EN
   logic [NUM_M-1:0] dec_gnt;
   logic [NUM_M-1:0] rsp_err_q;
   logic             decerr_q;

   assign dec_gnt  = i_m_req & ~m_hit;
   assign o_decerr = decerr_q;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         rsp_err_q <= '0;
         decerr_q  <= 1'b0;
      end else begin
         rsp_err_q <= ~m_hit;
         decerr_q  <= decerr_q | (|dec_gnt);
      end
   end
`endif

   // Slave-side mux and master grants. A write wins over a simultaneous read.
   always_comb begin
      o_m_gnt   = '0;
      o_s_addr  = '0;
      o_s_write = '0;
      o_s_read  = '0;
      o_s_size  = '0;
      o_s_din   = '0;
      for (int s = 0; s < NUM_S; s++) begin
         o_m_gnt = o_m_gnt | s_gnt[s];
         if (|s_gnt[s]) begin
            o_s_addr[s*XLEN +: XLEN] = i_m_addr[int'(s_idx[s])*XLEN +: XLEN];
            o_s_din[s*XLEN +: XLEN]  = i_m_din[int'(s_idx[s])*XLEN +: XLEN];
            o_s_size[s*4 +: 4]       = i_m_size[int'(s_idx[s])*4 +: 4];
            o_s_write[s]             = i_m_write[s_idx[s]];
            o_s_read[s]              = i_m_read[s_idx[s]] & ~i_m_write[s_idx[s]];
         end
      end
`ifdef BUS_XBAR_DECERR_EN
      o_m_gnt = o_m_gnt | dec_gnt;
`endif
      rsp_vld_d = o_m_gnt & i_m_read & ~i_m_write;
   end

   assign rsp_sel_d = m_tgt;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         rsp_vld_q <= '0;
         rsp_sel_q <= '0;
      end else begin
         rsp_vld_q <= rsp_vld_d;
         rsp_sel_q <= rsp_sel_d;
      end
   end

   // Slave read data is valid the cycle after the strobe, matching rsp_vld_q.
   always_comb begin
      o_m_rvalid = rsp_vld_q;
      o_m_dout   = '0;
      for (int m = 0; m < NUM_M; m++) begin
         if (rsp_vld_q[m]) begin
`ifdef BUS_XBAR_DECERR_EN
            if (rsp_err_q[m]) o_m_dout[m*XLEN +: XLEN] = XLEN'(DECERR_DATA);
            else
`endif
            o_m_dout[m*XLEN +: XLEN] = i_s_dout[int'(rsp_sel_q[m])*XLEN +: XLEN];
         end
      end
   end

endmodule

// File: tb/tb_bus_xbar_rr.sv
// Bench for bus_xbar_rr: a per-cycle reference model of decode, round-robin and the
// response path, plus directed literal checks, and a NUM_M=1/NUM_S=4 instance.
module tb_bus_xbar_rr;
   import bus_xbar_pkg::*;

   localparam int XLEN = 32;
   localparam int NM   = 3;
   localparam int NS   = 2;
   localparam logic [31:0] DEC = 32'hBADD_ADD0;

   logic clk = 1'b0;
   logic rst;
   logic chk_en = 1'b0;
   int   errors = 0;
   int   checks = 0;

   logic [NM-1:0]      m_req, m_gnt, m_write, m_read, m_rvalid;
   logic [NM*XLEN-1:0] m_addr, m_din, m_dout;
   logic [NM*4-1:0]    m_size;
   logic [NS*XLEN-1:0] s_addr, s_din, s_dout;
   logic [NS-1:0]      s_write, s_read;
   logic [NS*4-1:0]    s_size;
   logic               decerr;

   logic        q_req, q_gnt, q_write, q_read, q_rvalid;
   logic [31:0] q_addr, q_din, q_dout;
   logic [3:0]  q_size;
   logic [127:0] q_saddr, q_sdin, q_sdout;
   logic [3:0]  q_swrite, q_sread;
   logic [15:0] q_ssize;
   logic        q_decerr;

   assign s_dout  = {32'hA5A5_0001, 32'h1234_5678};
   assign q_sdout = {32'hD0D0_0003, 32'hD0D0_0002, 32'hD0D0_0001, 32'hD0D0_0000};

   always #5 clk = ~clk;

   bus_xbar_rr u_dut (
      .i_clk(clk), .i_rst(rst), .i_m_req(m_req), .o_m_gnt(m_gnt), .i_m_addr(m_addr),
      .i_m_write(m_write), .i_m_read(m_read), .i_m_size(m_size), .i_m_din(m_din),
      .o_m_dout(m_dout), .o_m_rvalid(m_rvalid),
`ifdef BUS_XBAR_DECERR_EN
      .o_decerr(decerr),
`endif
      .o_s_addr(s_addr), .o_s_write(s_write), .o_s_read(s_read), .o_s_size(s_size),
      .o_s_din(s_din), .i_s_dout(s_dout)
   );

   bus_xbar_rr #(
      .NUM_M(1), .NUM_S(4),
      .SLV_BASE({32'h4000_0000, 32'h3000_0000, 32'h2000_0000, 32'h1000_0000}),
      .SLV_MASK({4{32'hF000_0000}})
   ) u_dut4 (
      .i_clk(clk), .i_rst(rst), .i_m_req(q_req), .o_m_gnt(q_gnt), .i_m_addr(q_addr),
      .i_m_write(q_write), .i_m_read(q_read), .i_m_size(q_size), .i_m_din(q_din),
      .o_m_dout(q_dout), .o_m_rvalid(q_rvalid),
`ifdef BUS_XBAR_DECERR_EN
      .o_decerr(q_decerr),
`endif
      .o_s_addr(q_saddr), .o_s_write(q_swrite), .o_s_read(q_sread), .o_s_size(q_ssize),
      .o_s_din(q_sdin), .i_s_dout(q_sdout)
   );

`ifndef BUS_XBAR_DECERR_EN
   assign decerr   = 1'b0;
   assign q_decerr = 1'b0;
`endif

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   logic [31:0] base [NS] = '{32'h4000_0000, 32'h4000_4000};
   logic [31:0] mask [NS] = '{32'hFFFF_C000, 32'hFFFF_C000};
   bit  hit [NM];
   int  tgt [NM];
   int  win [NS];
   int  mptr[NS], nptr[NS];
   bit  mvld[NM], nvld[NM], merr[NM], nerr[NM];
   int  msel[NM], nsel[NM];
   bit  mdec, ndec;
   logic [NM-1:0]      e_gnt, e_rv;
   logic [NM*XLEN-1:0] e_md;
   logic [NS*XLEN-1:0] e_sa, e_sd;
   logic [NS-1:0]      e_sw, e_sr;
   logic [NS*4-1:0]    e_ss;

   always @(negedge clk) begin
      if (chk_en && rst) begin
         for (int m = 0; m < NM; m++) begin nvld[m] = 0; nsel[m] = 0; nerr[m] = 0; end
         for (int s = 0; s < NS; s++) nptr[s] = 0;
         ndec = 0;
      end else if (chk_en) begin
         e_gnt = '0; e_rv = '0; e_md = '0; e_sa = '0; e_sd = '0;
         e_sw = '0; e_sr = '0; e_ss = '0;
         for (int m = 0; m < NM; m++) begin
            hit[m] = 0; tgt[m] = 0;
            for (int s = 0; s < NS; s++)
               if (!hit[m] && ((m_addr[m*XLEN +: XLEN] & mask[s]) == base[s])) begin
                  hit[m] = 1; tgt[m] = s;
               end
         end
         for (int s = 0; s < NS; s++) begin
            win[s] = -1;
            for (int k = 0; k < NM; k++)
               if (win[s] < 0 && m_req[(mptr[s]+k)%NM] && hit[(mptr[s]+k)%NM]
                   && tgt[(mptr[s]+k)%NM] == s)
                  win[s] = (mptr[s] + k) % NM;
            if (win[s] >= 0) begin
               e_gnt[win[s]]          = 1'b1;
               e_sa[s*XLEN +: XLEN]   = m_addr[win[s]*XLEN +: XLEN];
               e_sd[s*XLEN +: XLEN]   = m_din[win[s]*XLEN +: XLEN];
               e_ss[s*4 +: 4]         = m_size[win[s]*4 +: 4];
               e_sw[s]                = m_write[win[s]];
               e_sr[s]                = m_read[win[s]] && !m_write[win[s]];
            end
         end
`ifdef BUS_XBAR_DECERR_EN
         for (int m = 0; m < NM; m++) if (m_req[m] && !hit[m]) e_gnt[m] = 1'b1;
`endif
         for (int m = 0; m < NM; m++)
            if (mvld[m]) begin
               e_rv[m] = 1'b1;
               e_md[m*XLEN +: XLEN] = merr[m] ? DEC : s_dout[msel[m]*XLEN +: XLEN];
            end
         chk("m_gnt", m_gnt, e_gnt);
         chk("s_read", s_read, e_sr);
         chk("s_write", s_write, e_sw);
         chk("s_addr", s_addr, e_sa);
         chk("s_din", s_din, e_sd);
         chk("s_size", s_size, e_ss);
         chk("m_rvalid", m_rvalid, e_rv);
         chk("m_dout", m_dout, e_md);
`ifdef BUS_XBAR_DECERR_EN
         chk("decerr", decerr, mdec);
`endif
         ndec = mdec;
         for (int m = 0; m < NM; m++) begin
            nvld[m] = e_gnt[m] && m_read[m] && !m_write[m];
            nsel[m] = tgt[m];
            nerr[m] = !hit[m];
            if (e_gnt[m] && !hit[m]) ndec = 1;
         end
         for (int s = 0; s < NS; s++) nptr[s] = (win[s] >= 0) ? (win[s] + 1) % NM : mptr[s];
      end
   end

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int m = 0; m < NM; m++) begin mvld[m] <= 0; msel[m] <= 0; merr[m] <= 0; end
         for (int s = 0; s < NS; s++) mptr[s] <= 0;
         mdec <= 0;
      end else begin
         for (int m = 0; m < NM; m++) begin
            mvld[m] <= nvld[m]; msel[m] <= nsel[m]; merr[m] <= nerr[m];
         end
         for (int s = 0; s < NS; s++) mptr[s] <= nptr[s];
         mdec <= ndec;
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      m_req = '0; m_write = '0; m_read = '0; m_addr = '0; m_din = '0; m_size = '0;
   endtask

   task automatic set_m(input int m, input bit rd, input bit wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] sz);
      m_req[m] = rd | wr; m_read[m] = rd; m_write[m] = wr;
      m_addr[m*XLEN +: XLEN] = a; m_din[m*XLEN +: XLEN] = d; m_size[m*4 +: 4] = sz;
   endtask

   task automatic do_reset();
      idle();
      @(posedge clk);
      #1 rst = 1'b1;
      #2 rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      idle();
      q_req = 0; q_write = 0; q_read = 0; q_addr = '0; q_din = '0; q_size = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_rvalid", m_rvalid, 3'b000);
      chk("reset_sread", s_read, 2'b00);
      chk("reset_dout", m_dout, '0);
      rst = 1'b0;
      chk_en = 1'b1;

      // single read, slave 0
      tick(); idle(); set_m(0, 1, 0, 32'h4000_0010, 32'h0, SIZE_WORD); #1;
      chk("t1_gnt", m_gnt, 3'b001);
      chk("t1_sread", s_read, 2'b01);
      chk("t1_saddr", s_addr[31:0], 32'h4000_0010);
      tick(); idle(); #1;
      chk("t1_rvalid", m_rvalid, 3'b001);
      chk("t1_dout", m_dout[31:0], 32'h1234_5678);

      // three masters contend for slave 0
      do_reset();
      for (int c = 0; c < 6; c++) begin
         tick(); idle();
         for (int m = 0; m < NM; m++) set_m(m, 1, 0, 32'h4000_0000 + 32'(m * 4), 0, SIZE_WORD);
         #1;
         chk("rr_gnt", m_gnt, 3'b001 << (c % 3));
      end
      tick(); idle();

      // read slave 0 and write slave 1 together
      tick(); idle();
      set_m(0, 1, 0, 32'h4000_0020, 0, SIZE_WORD);
      set_m(1, 0, 1, 32'h4000_4004, 32'hCAFE_F00D, SIZE_BYTE);
      #1;
      chk("par_gnt", m_gnt, 3'b011);
      chk("par_swrite", s_write, 2'b10);
      chk("par_sdin", s_din[63:32], 32'hCAFE_F00D);
      tick(); idle(); #1;
      chk("par_rvalid", m_rvalid, 3'b001);

      // read+write on one master is a write
      tick(); idle(); set_m(2, 1, 1, 32'h4000_0008, 32'h5555_AAAA, SIZE_HALF); #1;
      chk("rw_swrite", s_write, 2'b01);
      chk("rw_sread", s_read, 2'b00);
      tick(); idle(); #1;
      chk("rw_rvalid", m_rvalid, 3'b000);

      // back-to-back reads from master 1 to slave 1
      for (int i = 0; i < 3; i++) begin
         tick(); idle(); set_m(1, 1, 0, 32'h4000_4000 + 32'(i * 4), 0, SIZE_WORD); #1;
         if (i > 0) chk("b2b_rvalid", m_rvalid, 3'b010);
      end
      tick(); idle(); #1;
      chk("b2b_last_rvalid", m_rvalid, 3'b010);
      chk("b2b_last_dout", m_dout[63:32], 32'hA5A5_0001);

      // unmapped read
`ifdef BUS_XBAR_DECERR_EN
      tick(); idle(); set_m(2, 1, 0, 32'h9000_0000, 0, SIZE_WORD); #1;
      chk("unm_gnt", m_gnt, 3'b100);
      tick(); idle(); #1;
      chk("unm_rvalid", m_rvalid, 3'b100);
      chk("unm_dout", m_dout[95:64], 32'hBADD_ADD0);
      chk("unm_decerr", decerr, 1'b1);
`else
      tick(); idle(); set_m(2, 1, 0, 32'h9000_0000, 0, SIZE_WORD);
      for (int c = 0; c < 10; c++) begin
         #1 chk("unm_gnt", m_gnt, 3'b000);
         tick();
      end
      idle(); #1;
      chk("unm_rvalid", m_rvalid, 3'b000);
`endif

      // reset while a read response is pending
      tick(); idle(); set_m(1, 1, 0, 32'h4000_0030, 0, SIZE_WORD); #1;
      chk("rst_gnt", m_gnt, 3'b010);
      tick(); idle();
      rst = 1'b1;
      #1 rst = 1'b0;
      #1 chk("rst_rvalid_drop", m_rvalid, 3'b000);
      tick();
      for (int m = 0; m < NM; m++) set_m(m, 1, 0, 32'h4000_0040, 0, SIZE_WORD);
      #1 chk("rst_ptr_gnt", m_gnt, 3'b001);
      tick(); idle();

      // one master, four slaves
      for (int s = 0; s < 4; s++) begin
         tick();
         q_req = 1; q_read = 1; q_addr = 32'h1000_0000 * 32'(s + 1) + 32'h8; q_size = SIZE_WORD;
         #1;
         chk("x4_gnt", q_gnt, 1'b1);
         chk("x4_sread", q_sread, 4'b0001 << s);
         tick();
         q_req = 0; q_read = 0; q_addr = '0;
         #1;
         chk("x4_rvalid", q_rvalid, 1'b1);
         chk("x4_dout", q_dout, 32'hD0D0_0000 + 32'(s));
      end
      chk("x4_decerr", q_decerr, 1'b0);

      tick(); tick();
      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
